// File: rtl/arb_req_agent_if.sv
// rtl/arb_req_agent_if.sv - request/grant bundle between a requester agent and its arbiter/driver
// master = the agent; slave = whatever drives pushes and grants.
interface arb_req_agent_if #(
  parameter int REQ_NUM = 8,
  parameter int ID_W    = $clog2(REQ_NUM)
) ();
  logic [REQ_NUM-1:0] push;
  logic [REQ_NUM-1:0] push_ready;
  logic [REQ_NUM-1:0] reqs;
  logic [REQ_NUM-1:0] grants;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               err_multi;
  logic               err_spurious;
  logic               clr_err;

  modport master (
    input  push, grants, clr_err,
    output push_ready, reqs, gnt_valid, gnt_id, err_multi, err_spurious
  );

  modport slave (
    output push, grants, clr_err,
    input  push_ready, reqs, gnt_valid, gnt_id, err_multi, err_spurious
  );
endinterface

// File: rtl/arb_req_agent.sv
// rtl/arb_req_agent.sv - per-port pending counters feeding an arbiter, with grant retire and checking
// reqs/push_ready come only from registered counts, so no input reaches an output combinationally.
module arb_req_agent #(
  parameter int REQ_NUM = 8,
  parameter int CNT_W   = 4,
  parameter int ID_W    = $clog2(REQ_NUM)
) (
  input  logic           clk,
  input  logic           rstn,
  arb_req_agent_if.master bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt_q [REQ_NUM];
  logic [CNT_W-1:0]   cnt_d [REQ_NUM];
  logic [REQ_NUM-1:0] reqs_w;
  logic [REQ_NUM-1:0] ready_w;
  logic [REQ_NUM-1:0] acc_w;
  logic               one_hot;
  logic               multi_hot;
  logic               spurious;
  logic [ID_W-1:0]    id_enc;
  logic [ID_W-1:0]    gnt_id_q;
  logic               gnt_valid_q;
  logic               err_multi_q;
  logic               err_spurious_q;

  always_comb begin
    reqs_w  = '0;
    ready_w = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      reqs_w[i]  = (cnt_q[i] != '0);
      ready_w[i] = (cnt_q[i] != CNT_MAX);
    end
  end

  assign one_hot   = (bus.grants != '0) && ((bus.grants & (bus.grants - REQ_NUM'(1))) == '0);
  assign multi_hot = (bus.grants != '0) && !one_hot;
  assign acc_w     = bus.grants & reqs_w & {REQ_NUM{one_hot}};
  assign spurious  = one_hot && ((bus.grants & ~reqs_w) != '0);

  // A push at MAX is already masked by ready_w, so push+grant at MAX nets to a decrement.
  always_comb begin
    id_enc = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (acc_w[i]) id_enc = ID_W'(i);
      cnt_d[i] = cnt_q[i] + CNT_W'(bus.push[i] & ready_w[i]) - CNT_W'(acc_w[i]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REQ_NUM; i++) cnt_q[i] <= '0;
      gnt_valid_q    <= 1'b0;
      gnt_id_q       <= '0;
      err_multi_q    <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) cnt_q[i] <= cnt_d[i];
      gnt_valid_q <= |acc_w;
      if (|acc_w) gnt_id_q <= id_enc;
      err_multi_q    <= multi_hot | (err_multi_q & ~bus.clr_err);
      err_spurious_q <= spurious  | (err_spurious_q & ~bus.clr_err);
    end
  end

  assign bus.reqs         = reqs_w;
  assign bus.push_ready   = ready_w;
  assign bus.gnt_valid    = gnt_valid_q;
  assign bus.gnt_id       = gnt_id_q;
  assign bus.err_multi    = err_multi_q;
  assign bus.err_spurious = err_spurious_q;
endmodule

// File: tb/tb_arb_req_agent.sv
// tb/tb_arb_req_agent.sv - directed and round-robin traffic against a count-level model of the agent
module tb_arb_req_agent;
  localparam int N    = 8;
  localparam int MAXC = 15;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  arb_req_agent_if #(.REQ_NUM(N)) bus ();
  arb_req_agent #(.REQ_NUM(N), .CNT_W(4)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int n_checks = 0;
  int n_err    = 0;

  int         m_cnt [N]      = '{default: 0};
  int         m_push_acc [N] = '{default: 0};
  int         d_gnt [N]      = '{default: 0};
  logic       m_gv = 1'b0;
  logic [2:0] m_id = '0;
  logic       m_em = 1'b0;
  logic       m_es = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pending counts as plain integers, updated from the rules on each edge.
  always @(posedge clk or negedge rstn) begin : model
    int  ones;
    int  gi;
    logic acc;
    if (!rstn) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_gv = 1'b0; m_id = '0; m_em = 1'b0; m_es = 1'b0;
    end else begin
      ones = $countones(bus.grants);
      gi   = -1;
      for (int i = 0; i < N; i++) if (bus.grants[i]) gi = i;
      acc = (ones == 1) && (m_cnt[gi] > 0);
      if (ones >= 2) m_em = 1'b1; else if (bus.clr_err) m_em = 1'b0;
      if ((ones == 1) && (m_cnt[gi] == 0)) m_es = 1'b1; else if (bus.clr_err) m_es = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (bus.push[i] && (m_cnt[i] < MAXC)) begin
          m_cnt[i]++;
          m_push_acc[i]++;
        end
      end
      if (acc) begin
        m_cnt[gi]--;
        m_id = gi[2:0];
      end
      m_gv = acc;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] er;
    logic [N-1:0] ep;
    for (int i = 0; i < N; i++) begin
      er[i] = (m_cnt[i] != 0);
      ep[i] = (m_cnt[i] != MAXC);
    end
    chk("reqs", 32'(bus.reqs), 32'(er));
    chk("push_ready", 32'(bus.push_ready), 32'(ep));
    chk("gnt_valid", 32'(bus.gnt_valid), 32'(m_gv));
    chk("gnt_id", 32'(bus.gnt_id), 32'(m_id));
    chk("err_multi", 32'(bus.err_multi), 32'(m_em));
    chk("err_spurious", 32'(bus.err_spurious), 32'(m_es));
    if (bus.gnt_valid) d_gnt[bus.gnt_id]++;
  end

  task automatic cyc(input logic [N-1:0] p, input logic [N-1:0] g, input logic c);
    bus.push = p; bus.grants = g; bus.clr_err = c;
    @(posedge clk); #1;
    bus.push = '0; bus.grants = '0; bus.clr_err = 1'b0;
  endtask

  task automatic drain(input int p, output int n);
    logic [N-1:0] g;
    g = '0; g[p] = 1'b1; n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!bus.reqs[p]) break;
      cyc('0, g, 1'b0);
      if (bus.gnt_valid && (bus.gnt_id == 3'(p))) n++;
    end
  endtask

  task automatic rr(input logic [N-1:0] r, inout int ptr, output logic [N-1:0] g);
    int idx;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      idx = (ptr + k) % N;
      if (r[idx]) begin
        g[idx] = 1'b1;
        ptr = idx;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int ptr;
    logic [N-1:0] g;
    bus.push = '0; bus.grants = '0; bus.clr_err = 1'b0;
    rstn = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      bus.push = ~bus.push;
    end
    chk("rst_reqs", 32'(bus.reqs), 32'h0);
    chk("rst_ready", 32'(bus.push_ready), 32'hFF);
    chk("rst_gv", 32'(bus.gnt_valid), 32'h0);
    chk("rst_em", 32'(bus.err_multi), 32'h0);
    chk("rst_es", 32'(bus.err_spurious), 32'h0);
    bus.push = '0;
    rstn = 1'b1;

    cyc(8'h08, 8'h00, 1'b0);
    chk("push_lat_reqs", 32'(bus.reqs), 32'h08);
    cyc(8'h00, 8'h08, 1'b0);
    chk("gnt_lat_gv", 32'(bus.gnt_valid), 32'h1);
    chk("gnt_lat_id", 32'(bus.gnt_id), 32'h3);
    chk("gnt_lat_reqs", 32'(bus.reqs), 32'h0);

    repeat (15) cyc(8'h01, 8'h00, 1'b0);
    chk("fill_ready0", 32'(bus.push_ready[0]), 32'h0);
    cyc(8'h01, 8'h00, 1'b0);
    drain(0, n);
    chk("fill_drain_cnt", 32'(n), 32'd15);
    chk("fill_drain_reqs0", 32'(bus.reqs[0]), 32'h0);

    repeat (15) cyc(8'h20, 8'h00, 1'b0);
    cyc(8'h20, 8'h20, 1'b0);
    chk("same_max_gv", 32'(bus.gnt_valid), 32'h1);
    chk("same_max_id", 32'(bus.gnt_id), 32'h5);
    drain(5, n);
    chk("same_max_cnt", 32'(n), 32'd14);
    repeat (2) cyc(8'h20, 8'h00, 1'b0);
    cyc(8'h20, 8'h20, 1'b0);
    drain(5, n);
    chk("same_two_cnt", 32'(n), 32'd2);

    cyc(8'h06, 8'h00, 1'b0);
    cyc(8'h00, 8'h06, 1'b0);
    chk("multi_gv", 32'(bus.gnt_valid), 32'h0);
    chk("multi_em", 32'(bus.err_multi), 32'h1);
    cyc(8'h00, 8'h00, 1'b1);
    chk("multi_clr", 32'(bus.err_multi), 32'h0);
    cyc(8'h00, 8'h06, 1'b1);
    chk("multi_set_wins", 32'(bus.err_multi), 32'h1);
    drain(1, n);
    chk("multi_cnt1", 32'(n), 32'd1);
    drain(2, n);
    chk("multi_cnt2", 32'(n), 32'd1);
    cyc(8'h00, 8'h00, 1'b1);

    cyc(8'h01, 8'h00, 1'b0);
    chk("spur_reqs", 32'(bus.reqs), 32'h01);
    cyc(8'h00, 8'h80, 1'b0);
    chk("spur_es", 32'(bus.err_spurious), 32'h1);
    chk("spur_gv", 32'(bus.gnt_valid), 32'h0);
    drain(0, n);
    chk("spur_cnt0", 32'(n), 32'd1);
    cyc(8'h00, 8'h00, 1'b1);
    chk("spur_clr", 32'(bus.err_spurious), 32'h0);

    cyc(8'hFF, 8'h00, 1'b0);
    cyc(8'hFF, 8'h00, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_reqs", 32'(bus.reqs), 32'h0);
    chk("midrst_ready", 32'(bus.push_ready), 32'hFF);
    bus.push = 8'hFF;
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.push = '0;
    cyc(8'h00, 8'h00, 1'b0);
    chk("midrst_lost", 32'(bus.reqs), 32'h0);

    for (int i = 0; i < N; i++) begin
      m_push_acc[i] = 0;
      d_gnt[i] = 0;
    end
    ptr = N - 1;
    repeat (500) begin
      rr(bus.reqs, ptr, g);
      cyc(N'($urandom), g, 1'b0);
    end
    for (int k = 0; k < 200; k++) begin
      if (bus.reqs == '0) break;
      rr(bus.reqs, ptr, g);
      cyc('0, g, 1'b0);
    end
    @(negedge clk); #1;
    chk("rand_drained", 32'(bus.reqs), 32'h0);
    for (int i = 0; i < N; i++) chk($sformatf("rand_conserve_%0d", i), 32'(d_gnt[i]), 32'(m_push_acc[i]));
    chk("rand_em", 32'(bus.err_multi), 32'h0);
    chk("rand_es", 32'(bus.err_spurious), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
